// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller: fixed green/yellow/all-red cycle with request-driven
// early green termination and a flashing-yellow night mode entered through all-red.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS     = 6,
  parameter int MIN_GREEN_TICKS = 2,
  parameter int YELLOW_TICKS    = 2,
  parameter int ALLRED_TICKS    = 1,
  parameter int FLASH_TICKS     = 1,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic [1:0] req,
  input  logic       night_mode,
  output logic [1:0] red_light,
  output logic [1:0] yellow_light,
  output logic [1:0] green_light,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    G0    = 3'd0,
    Y0    = 3'd1,
    AR0   = 3'd2,
    G1    = 3'd3,
    Y1    = 3'd4,
    AR1   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_TICKS - 1);

  // Kept as plain bits so an illegal code (7) is representable and recoverable.
  logic [2:0]       state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       req_pending;
  logic [1:0]       pending_next;
  logic             flash_on;
  logic             flash_next;
  logic             g0_exit;
  logic             g1_exit;
  logic             yellow_exit;
  logic             allred_exit;
  logic             entering;
  logic             flash_wrap;

  assign g0_exit     = tick_en && ((cnt == GREEN_LAST) || (req_pending[1] && (cnt >= MIN_LAST)));
  assign g1_exit     = tick_en && ((cnt == GREEN_LAST) || (req_pending[0] && (cnt >= MIN_LAST)));
  assign yellow_exit = tick_en && (cnt == YELLOW_LAST);
  assign allred_exit = tick_en && (cnt == ALLRED_LAST);

  // Next-state selection
  always_comb begin
    state_next = AR1;
    case (state)
      G0:      state_next = g0_exit ? Y0 : G0;
      Y0:      state_next = yellow_exit ? AR0 : Y0;
      AR0:     state_next = allred_exit ? (night_mode ? FLASH : G1) : AR0;
      G1:      state_next = g1_exit ? Y1 : G1;
      Y1:      state_next = yellow_exit ? AR1 : Y1;
      AR1:     state_next = allred_exit ? (night_mode ? FLASH : G0) : AR1;
      FLASH:   state_next = night_mode ? FLASH : AR1;
      default: state_next = AR1;
    endcase
  end

  // Counter, flash phase and sticky request bookkeeping for the next cycle
  always_comb begin
    entering   = (state_next != state);
    flash_wrap = (state == FLASH) && night_mode && tick_en && (cnt == FLASH_LAST);
    if (entering || flash_wrap) begin
      cnt_next = {CNT_W{1'b0}};
    end else if (tick_en) begin
      cnt_next = cnt + 1'b1;
    end else begin
      cnt_next = cnt;
    end
    if (entering && (state_next == FLASH)) begin
      flash_next = 1'b1;
    end else if (flash_wrap) begin
      flash_next = ~flash_on;
    end else begin
      flash_next = flash_on;
    end
    // A request is ignored while its own road is green; entering that green clears it.
    pending_next[0] = ((state_next == G0) && (state != G0)) ? 1'b0
                    : (req_pending[0] | (req[0] & (state != G0)));
    pending_next[1] = ((state_next == G1) && (state != G1)) ? 1'b0
                    : (req_pending[1] | (req[1] & (state != G1)));
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= AR1;
      cnt         <= {CNT_W{1'b0}};
      req_pending <= 2'b00;
      flash_on    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      req_pending <= pending_next;
      flash_on    <= flash_next;
    end
  end

  // Moore output decode; anything unexpected shows all red
  always_comb begin
    red_light    = 2'b11;
    yellow_light = 2'b00;
    green_light  = 2'b00;
    case (state)
      G0:      begin red_light = 2'b10; green_light  = 2'b01; end
      Y0:      begin red_light = 2'b10; yellow_light = 2'b01; end
      G1:      begin red_light = 2'b01; green_light  = 2'b10; end
      Y1:      begin red_light = 2'b01; yellow_light = 2'b10; end
      FLASH:   begin red_light = 2'b00; yellow_light = {flash_on, flash_on}; end
      default: begin red_light = 2'b11; end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a dwell-table reference model.
module tb_traffic_light_ctrl;

  localparam int GREEN  = 6;
  localparam int MING   = 2;
  localparam int YELLOW = 2;
  localparam int ALLRED = 1;
  localparam int FLASHT = 1;

  logic       clk;
  logic       reset;
  logic       tick_en;
  logic [1:0] req;
  logic       night_mode;
  logic [1:0] red_light;
  logic [1:0] yellow_light;
  logic [1:0] green_light;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase code, ticks completed in phase, sticky requests, flash level
  int   m_phase;
  int   m_cnt;
  bit   m_pend [2];
  bit   m_flash;

  int   prev_phase = 5;
  int   last_entry [8];
  int   last_dwell [8];
  int   g0_q [$];

  traffic_light_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .tick_en      (tick_en),
    .req          (req),
    .night_mode   (night_mode),
    .red_light    (red_light),
    .yellow_light (yellow_light),
    .green_light  (green_light),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 5; m_cnt = 0; m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_flash = 1'b0;
  endtask

  // Phases 0..5 are (road, kind) with kind 0=green 1=yellow 2=all-red; 6 flash, 7 illegal
  task automatic model_step(input bit tick, input logic [1:0] rq, input bit night);
    int nxt, c, road, kind, dur;
    bit fl, done;
    nxt = m_phase; c = m_cnt; fl = m_flash;
    if (m_phase == 7) begin
      nxt = 5;
    end else if (m_phase == 6) begin
      if (!night) nxt = 5;
      else if (tick) begin
        if (m_cnt + 1 == FLASHT) begin c = 0; fl = !fl; end
        else c = m_cnt + 1;
      end
    end else begin
      road = m_phase / 3;
      kind = m_phase % 3;
      dur  = (kind == 0) ? GREEN : (kind == 1) ? YELLOW : ALLRED;
      done = tick && ((m_cnt + 1 >= dur) || (kind == 0 && m_pend[1-road] && m_cnt + 1 >= MING));
      if (done) nxt = (kind == 2) ? (night ? 6 : (road == 0 ? 3 : 0)) : m_phase + 1;
      else if (tick) c = m_cnt + 1;
    end
    if (nxt != m_phase) begin
      c = 0;
      if (nxt == 6) fl = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (nxt == 3*i && m_phase != 3*i) m_pend[i] = 1'b0;
      else if (rq[i] && m_phase != 3*i) m_pend[i] = 1'b1;
    end
    m_phase = nxt; m_cnt = c; m_flash = fl;
  endtask

  task automatic exp_lights(input int p, input bit f, output logic [1:0] r, output logic [1:0] y,
                            output logic [1:0] g);
    r = 2'b11; y = 2'b00; g = 2'b00;
    if (p == 6) begin
      r = 2'b00; y = f ? 2'b11 : 2'b00;
    end else if (p < 6) begin
      for (int rd = 0; rd < 2; rd++) begin
        if (p == 3*rd || p == 3*rd + 1) r[rd] = 1'b0;
        if (p == 3*rd) g[rd] = 1'b1;
        if (p == 3*rd + 1) y[rd] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] er, ey, eg;
    logic [1:0] ep;
    exp_lights(m_phase, m_flash, er, ey, eg);
    ep = {m_pend[1], m_pend[0]};
    check("phase",  32'(phase),           32'(m_phase));
    check("red",    32'(red_light),       32'(er));
    check("yellow", 32'(yellow_light),    32'(ey));
    check("green",  32'(green_light),     32'(eg));
    check("cnt",    32'(dut.cnt),         32'(m_cnt));
    check("pend",   32'(dut.req_pending), 32'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(tick_en, req, night_mode);
    #1;
    cyc++;
    compare_all();
    if (32'(phase) != prev_phase) begin
      last_dwell[prev_phase] = cyc - last_entry[prev_phase];
      last_entry[phase] = cyc;
      if (phase == 3'd0) g0_q.push_back(cyc);
      prev_phase = 32'(phase);
    end
  endtask

  task automatic wait_phase(input int p, input int limit);
    int k = 0;
    while (32'(phase) != p && k < limit) begin
      step();
      k++;
    end
    check("wait_phase", 32'(phase), 32'(p));
  endtask

  initial begin
    reset = 1'b0; tick_en = 1'b1; req = 2'b00; night_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin last_entry[i] = 0; last_dwell[i] = 0; end
    #1 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Free-running default cycle: 18-cycle period, G0 lasts 6
    for (int i = 0; i < 40; i++) step();
    check("period", (g0_q.size() >= 2) ? 32'(g0_q[1] - g0_q[0]) : 32'd0, 32'd18);
    check("g0_dwell", 32'(last_dwell[0]), 32'd6);
    check("ar1_dwell", 32'(last_dwell[5]), 32'd1);

    // Pulse req[1] at G0 start: G0 cut to 2, G1 still full
    wait_phase(5, 40);
    wait_phase(0, 5);
    req = 2'b10;
    step();
    req = 2'b00;
    for (int i = 0; i < 16; i++) step();
    check("g0_early", 32'(last_dwell[0]), 32'd2);
    check("g1_full", 32'(last_dwell[3]), 32'd6);

    // Ticks every 4th cycle: dwell stretches 4x
    for (int i = 0; i < 130; i++) begin
      tick_en = ((cyc % 4) == 3);
      step();
    end
    tick_en = 1'b1;
    check("g0_dwell_x4", 32'(last_dwell[0]), 32'd24);
    check("y0_dwell_x4", 32'(last_dwell[1]), 32'd8);

    // Night mode raised in G0: through Y0, AR0 into FLASH, then back via AR1
    wait_phase(0, 40);
    night_mode = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("in_flash", 32'(phase), 32'd6);
    night_mode = 1'b0;
    step();
    check("flash_exit", 32'(phase), 32'd5);
    step();
    check("g0_after_flash", 32'(phase), 32'd0);

    // Asynchronous reset mid-G1
    wait_phase(3, 40);
    #3 reset = 1'b1;
    #1 model_reset();
    compare_all();
    check("rst_red", 32'(red_light), 32'd3);
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    reset = 1'b0;
    step();
    check("g0_after_rst", 32'(phase), 32'd0);

    // Illegal state recovery
    for (int i = 0; i < 3; i++) step();
    force dut.state = 3'd7;
    #1 m_phase = 7;
    compare_all();
    release dut.state;
    step();
    check("illegal_recover", 32'(phase), 32'd5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick_en = 1'($urandom_range(0, 1));
      req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) night_mode = ~night_mode;
      step();
    end
    night_mode = 1'b0; req = 2'b00; tick_en = 1'b1;
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
